// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared widths, register map and FSM state type for the SPI write initiator
package spi_pkg;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;

    localparam logic [ADDR_W-1:0] EN_OUT_7_0  = 7'h00;
    localparam logic [ADDR_W-1:0] EN_OUT_15_8 = 7'h01;
    localparam logic [ADDR_W-1:0] EN_PWM_7_0  = 7'h02;
    localparam logic [ADDR_W-1:0] EN_PWM_15_8 = 7'h03;
    localparam logic [ADDR_W-1:0] PWM_DUTY    = 7'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_state_e;

    // Write frame: leading 1 marks a write, then address, then data, MSB first.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [ADDR_W-1:0] addr,
                                                       input logic [DATA_W-1:0] data);
        return {1'b1, addr, data};
    endfunction

endpackage

// File: rtl/spi_ctrl_clkdiv.sv
// rtl/spi_ctrl_clkdiv.sv - SCLK half-period counter producing rise/fall tick strobes
module spi_ctrl_clkdiv #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic sclk_i,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       tick;

    assign tick = en_i && (cnt_q == DIV_LAST);

    // Counter is held at zero while disabled so every frame starts on a fresh half-period.
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rise_o = tick && !sclk_i;
    assign fall_o = tick &&  sclk_i;

endmodule

// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI mode-0 initiator serialising single-byte register writes
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 8,
    parameter int CS_GAP  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              ncs,
    output logic              sclk,
    output logic              copi,
    output logic              busy,
    output logic              done
);

    localparam logic [7:0] GAP_LAST  = 8'(CS_GAP - 1);
    localparam logic [4:0] LAST_EDGE = 5'(FRAME_W);

    spi_state_e         state_q, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [4:0]         edge_cnt_q, edge_cnt_d;
    logic [7:0]         gap_cnt_q, gap_cnt_d;
    logic               ncs_q, ncs_d;
    logic               sclk_q, sclk_d;
    logic               copi_q, copi_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_en, rise_tick, fall_tick;

    assign div_en = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);

    spi_ctrl_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (div_en),
        .sclk_i (sclk_q),
        .rise_o (rise_tick),
        .fall_o (fall_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        edge_cnt_d = edge_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        ncs_d      = ncs_q;
        sclk_d     = sclk_q;
        copi_d     = copi_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    shift_d    = build_frame(req_addr, req_data);
                    copi_d     = 1'b1;
                    ncs_d      = 1'b0;
                    ready_d    = 1'b0;
                    busy_d     = 1'b1;
                    edge_cnt_d = '0;
                    state_d    = ST_SETUP;
                end
            end
            // Leaving SETUP is the first SCLK rise, so the edge count starts at one.
            ST_SETUP: begin
                if (rise_tick) begin
                    sclk_d     = 1'b1;
                    edge_cnt_d = 5'd1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (rise_tick) begin
                    sclk_d     = 1'b1;
                    edge_cnt_d = edge_cnt_q + 5'd1;
                end else if (fall_tick) begin
                    sclk_d = 1'b0;
                    if (edge_cnt_q == LAST_EDGE) begin
                        state_d = ST_HOLD;
                    end else begin
                        shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                        copi_d  = shift_q[FRAME_W-2];
                    end
                end
            end
            // In HOLD sclk is low, so the divider's next tick arrives as a rise strobe.
            ST_HOLD: begin
                if (rise_tick) begin
                    ncs_d     = 1'b1;
                    copi_d    = 1'b0;
                    done_d    = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    ready_d   = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            edge_cnt_q <= '0;
            gap_cnt_q  <= '0;
            ncs_q      <= 1'b1;
            sclk_q     <= 1'b0;
            copi_q     <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            edge_cnt_q <= edge_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            ncs_q      <= ncs_d;
            sclk_q     <= sclk_d;
            copi_q     <= copi_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign req_ready = ready_q;
    assign ncs       = ncs_q;
    assign sclk      = sclk_q;
    assign copi      = copi_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - self-checking bench with a behavioural SPI peripheral and register model
module tb_spi_controller;
    import spi_pkg::*;

    localparam int DIV       = 4;
    localparam int GAP       = 5;
    localparam int FRAME_CYC = 33 * DIV;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       req_valid = 1'b0;
    logic [6:0] req_addr  = '0;
    logic [7:0] req_data  = '0;
    logic       req_ready, ncs, sclk, copi, busy, done;

    spi_controller #(.CLK_DIV(DIV), .CS_GAP(GAP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .ncs       (ncs),
        .sclk      (sclk),
        .copi      (copi),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral: samples copi on sclk rises while ncs is low and commits a write on ncs rise.
    logic        prev_ncs = 1'b1, prev_sclk = 1'b0, prev_copi = 1'b0, in_frame = 1'b0;
    logic [15:0] sh = '0, last_frame = '0;
    int          nb = 0, low = 0, last_nb = 0, last_low = 0, high_run = 0, last_gap = 0;
    int          done_cnt = 0, done_bad = 0, sclk_bad = 0, copi_bad = 0;
    logic [7:0]  periph [0:4] = '{default: 8'h00};
    logic [7:0]  model  [0:4] = '{default: 8'h00};

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame  = 1'b0;
            prev_ncs  = 1'b1;
            prev_sclk = 1'b0;
            prev_copi = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                if (!(!prev_ncs && ncs)) done_bad++;
            end
            if (ncs && sclk) sclk_bad++;
            if (!prev_ncs && !ncs && (copi != prev_copi) && !(prev_sclk && !sclk)) copi_bad++;
            if (prev_ncs && !ncs) begin
                in_frame = 1'b1;
                sh       = '0;
                nb       = 0;
                low      = 0;
                last_gap = high_run;
            end
            if (!ncs) begin
                low++;
                if (!prev_sclk && sclk) begin
                    sh = {sh[14:0], copi};
                    nb++;
                end
            end else begin
                high_run = prev_ncs ? high_run + 1 : 1;
            end
            if (!prev_ncs && ncs && in_frame) begin
                if (!done) done_bad++;
                last_frame = sh;
                last_nb    = nb;
                last_low   = low;
                in_frame   = 1'b0;
                if (nb == 16 && sh[15] && sh[14:8] < 7'd5) periph[sh[10:8]] = sh[7:0];
            end
            prev_ncs  = ncs;
            prev_sclk = sclk;
            prev_copi = copi;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [6:0] a, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        req_addr  = a;
        req_data  = d;
        req_valid = 1'b1;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("accept_timeout", 0, 1);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 7'($urandom);
        req_data  = 8'($urandom);
        if (a < 7'd5) model[a[2:0]] = d;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || !req_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("idle_timeout", 0, 1);
    endtask

    task automatic send_check(input string tag, input logic [6:0] a, input logic [7:0] d);
        issue(a, d);
        wait_idle();
        chk({tag, "_frame"}, {16'h0, last_frame}, {16'h0, build_frame(a, d)});
    endtask

    initial begin
        int          t1, t2, d0, n, rdy_bad;
        logic [6:0]  ra;
        logic [7:0]  rd, base;

        repeat (3) @(negedge clk);
        chk("rst_ncs", ncs, 1);
        chk("rst_sclk", sclk, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ncs_rel", ncs, 1);
        chk("rst_sclk_rel", sclk, 0);
        chk("rst_copi", copi, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // Single write with spec-given values.
        d0 = done_cnt;
        send_check("single", EN_OUT_7_0, 8'hA5);
        chk("single_frame_raw", {16'h0, last_frame}, 32'h80A5);
        chk("single_low", last_low, FRAME_CYC);
        chk("single_rises", last_nb, 16);
        chk("single_done", done_cnt - d0, 1);
        chk("single_reg", periph[0], 8'hA5);

        // Back-to-back with req_valid held through the first frame.
        @(negedge clk);
        req_addr = PWM_DUTY; req_data = 8'h80; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 2000) begin @(negedge clk); n++; end
        t1 = cyc;
        @(negedge clk);
        req_addr = EN_PWM_7_0; req_data = 8'hFF;
        n = 0;
        while (!req_ready && n < 2000) begin @(negedge clk); n++; end
        t2 = cyc;
        chk("b2b_period", t2 - t1, FRAME_CYC + GAP + 1);
        @(negedge clk);
        req_valid = 1'b0;
        model[4] = 8'h80; model[2] = 8'hFF;
        wait_idle();
        chk("b2b_gap_min", last_gap >= GAP, 1);
        chk("b2b_frame2", {16'h0, last_frame}, 32'h82FF);
        chk("b2b_duty", periph[4], 8'h80);
        chk("b2b_pwm", periph[2], 8'hFF);

        // Busy rejection: noise on the request port while a frame is in flight.
        d0 = done_cnt;
        rdy_bad = 0;
        issue(EN_PWM_15_8, 8'h5A);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            req_valid = 1'($urandom);
            req_addr  = 7'($urandom);
            req_data  = 8'($urandom);
            if (req_ready) rdy_bad++;
        end
        req_valid = 1'b0;
        wait_idle();
        chk("busy_ready_low", rdy_bad, 0);
        chk("busy_frame", {16'h0, last_frame}, 32'h835A);
        chk("busy_one_done", done_cnt - d0, 1);

        // Reset after the 5th sclk rise: frame aborted, no done, peripheral unchanged.
        d0 = done_cnt;
        issue(EN_OUT_15_8, 8'hC3);
        model[1] = periph[1];
        n = 0;
        while (nb < 5 && n < 1000) begin @(negedge clk); n++; end
        chk("mid_reach5", nb >= 5, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_ncs", ncs, 1);
        chk("mid_sclk", sclk, 0);
        chk("mid_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_no_done", done_cnt - d0, 0);
        send_check("after_rst", EN_OUT_15_8, 8'h3C);
        chk("after_rst_reg", periph[1], 8'h3C);

        // Address sweep with distinct random data, then an unmapped address.
        base = 8'($urandom);
        for (int i = 0; i < 5; i++) send_check("sweep", 7'(i), 8'(base + 8'(i * 51)));
        send_check("sweep_unmapped", 7'h05, 8'hEE);
        for (int i = 0; i < 5; i++) chk("sweep_reg", periph[i], model[i]);

        // Random writes, including unmapped addresses.
        for (int k = 0; k < 6; k++) begin
            ra = 7'($urandom_range(0, 7));
            rd = 8'($urandom);
            send_check("rand", ra, rd);
        end
        for (int i = 0; i < 5; i++) chk("rand_reg", periph[i], model[i]);

        chk("done_coincident", done_bad, 0);
        chk("sclk_idle_low", sclk_bad, 0);
        chk("copi_on_fall", copi_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
